lsu_mem_responder: RTL

LSU_MEM_RESPONDER -- requirements
Module: lsu_mem_responder

---
 rtl/lsu_mem_responder.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_responder.sv
// lsu_mem_responder
//   Shared single-port memory serving NUM_CHANNELS load/store channels.
//   Each channel contributes two requesters (read at index ch, write at
//   index NUM_CHANNELS+ch). Every requester walks IDLE -> ACCESS -> RESPOND.
//   A round-robin arbiter grants one IDLE requester per edge. Because ACCESS
//   lasts exactly one cycle, at most one requester owns the array at a time.
//
// Ports
//   clk               rising-edge clock
//   reset             asynchronous active-low reset (array contents preserved)
//   mem_read_valid    per-channel read request
//   mem_read_address  packed read addresses, channel i at [i*ADDR_BITS +: ADDR_BITS]
//   mem_read_ready    per-channel read response (four-phase handshake)
//   mem_read_data     packed read data, held until the channel's next read
//   mem_write_valid   per-channel write request
//   mem_write_address packed write addresses
//   mem_write_data    packed write data
//   mem_write_ready   per-channel write acknowledge (four-phase handshake)
module lsu_mem_responder #(
  parameter int NUM_CHANNELS = 4,
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_CHANNELS-1:0]           mem_read_valid,
  input  logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_read_address,
  output logic [NUM_CHANNELS-1:0]           mem_read_ready,
  output logic [NUM_CHANNELS*DATA_BITS-1:0] mem_read_data,
  input  logic [NUM_CHANNELS-1:0]           mem_write_valid,
  input  logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_write_address,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0] mem_write_data,
  output logic [NUM_CHANNELS-1:0]           mem_write_ready
);

  localparam int N     = NUM_CHANNELS;
  localparam int R     = 2 * NUM_CHANNELS;
  localparam int IDX_W = (R > 1) ? $clog2(R) : 1;
  localparam int DEPTH = 2 ** ADDR_BITS;

  typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

  state_t                      state_q [R];
  state_t                      state_d [R];
  logic [ADDR_BITS-1:0]        addr_q  [R];
  logic [ADDR_BITS-1:0]        addr_d  [R];
  logic [N-1:0][DATA_BITS-1:0] wdata_q, wdata_d;
  logic [N-1:0][DATA_BITS-1:0] rdata_q, rdata_d;
  logic [N-1:0]                rready_q, rready_d;
  logic [N-1:0]                wready_q, wready_d;
  logic [IDX_W-1:0]            last_grant_q, last_grant_d;

  logic [DATA_BITS-1:0]        mem [DEPTH];

  logic [R-1:0]                req_valid;
  logic [ADDR_BITS-1:0]        req_addr [R];
  logic                        gnt_vld;
  logic [IDX_W-1:0]            gnt_idx;
  logic                        acc_vld, acc_wr;
  logic [ADDR_BITS-1:0]        acc_addr;
  logic [DATA_BITS-1:0]        acc_wdata, acc_rdata;

  // (base + k) mod R for 1 <= k <= R
  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= R) s = s - R;
    return IDX_W'(s);
  endfunction

  assign req_valid = {mem_write_valid, mem_read_valid};

  always_comb begin
    for (int c = 0; c < N; c++) begin
      req_addr[c]     = mem_read_address[c*ADDR_BITS +: ADDR_BITS];
      req_addr[N + c] = mem_write_address[c*ADDR_BITS +: ADDR_BITS];
    end
  end

  // Round-robin: scan from farthest to nearest so the requester closest to
  // last_grant+1 is the final (winning) assignment.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = R; k >= 1; k--) begin
      if (state_q[wrap_idx(last_grant_q, k)] == IDLE && req_valid[wrap_idx(last_grant_q, k)]) begin
        gnt_vld = 1'b1;
        gnt_idx = wrap_idx(last_grant_q, k);
      end
    end
  end

  // Single array port, owned by whichever requester is in ACCESS.
  always_comb begin
    acc_vld   = 1'b0;
    acc_wr    = 1'b0;
    acc_addr  = '0;
    acc_wdata = '0;
    for (int c = 0; c < N; c++) begin
      if (state_q[c] == ACCESS) begin
        acc_vld  = 1'b1;
        acc_addr = addr_q[c];
      end
      if (state_q[N + c] == ACCESS) begin
        acc_vld   = 1'b1;
        acc_wr    = 1'b1;
        acc_addr  = addr_q[N + c];
        acc_wdata = wdata_q[c];
      end
    end
  end

  assign acc_rdata = mem[acc_addr];

  always_comb begin
    for (int r = 0; r < R; r++) begin
      state_d[r] = state_q[r];
      addr_d[r]  = addr_q[r];
    end
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    rready_d     = rready_q;
    wready_d     = wready_q;
    last_grant_d = gnt_vld ? gnt_idx : last_grant_q;

    for (int r = 0; r < R; r++) begin
      unique case (state_q[r])
        IDLE: begin
          if (gnt_vld && gnt_idx == IDX_W'(r)) begin
            state_d[r] = ACCESS;
            addr_d[r]  = req_addr[r];
          end
        end
        ACCESS:  state_d[r] = RESPOND;
        // Dropping valid in RESPOND completes the handshake; no re-grant on this edge.
        RESPOND: if (!req_valid[r]) state_d[r] = IDLE;
        default: state_d[r] = IDLE;
      endcase
    end

    for (int c = 0; c < N; c++) begin
      if (gnt_vld && gnt_idx == IDX_W'(N + c)) wdata_d[c] = mem_write_data[c*DATA_BITS +: DATA_BITS];

      if (state_q[c] == ACCESS) begin
        rdata_d[c]  = acc_rdata;
        rready_d[c] = 1'b1;
      end else if (state_q[c] == RESPOND && !req_valid[c]) begin
        rready_d[c] = 1'b0;
      end

      if (state_q[N + c] == ACCESS) begin
        wready_d[c] = 1'b1;
      end else if (state_q[N + c] == RESPOND && !req_valid[N + c]) begin
        wready_d[c] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < R; r++) state_q[r] <= IDLE;
      rdata_q      <= '0;
      rready_q     <= '0;
      wready_q     <= '0;
      last_grant_q <= IDX_W'(R - 1);
    end else begin
      for (int r = 0; r < R; r++) state_q[r] <= state_d[r];
      rdata_q      <= rdata_d;
      rready_q     <= rready_d;
      wready_q     <= wready_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Captured request fields only matter while the requester is busy.
  always_ff @(posedge clk) begin
    for (int r = 0; r < R; r++) addr_q[r] <= addr_d[r];
    wdata_q <= wdata_d;
  end

  // Storage is never cleared by reset.
  always_ff @(posedge clk) begin
    if (acc_vld && acc_wr) mem[acc_addr] <= acc_wdata;
  end

  assign mem_read_ready  = rready_q;
  assign mem_write_ready = wready_q;
  assign mem_read_data   = rdata_q;

endmodule
